// File: rtl/store_unit_pkg.sv
// Shared types for the MEM-stage store path: operand/op types, FSM encoding,
// and the registered bus beat.
package store_unit_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_LB  = 4'd6,
        OP_LH  = 4'd7,
        OP_LW  = 4'd8,
        OP_SB  = 4'd9,
        OP_SH  = 4'd10,
        OP_SW  = 4'd11,
        OP_BEQ = 4'd12,
        OP_JAL = 4'd13
    } oper_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } st_state_t;

    localparam int BUS_TIMEOUT_DEFAULT = 16;

    typedef struct packed {
        word_t addr;
        word_t wdata;
        be_t   be;
    } bus_beat_t;

    function automatic logic is_store_op(input oper_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/store_unit_align.sv
// Byte-lane steering for SB/SH/SW: enables, replicated write data and the
// raw misalignment flag. Non-store ops produce all zeros.
module store_align
    import store_unit_pkg::*;
(
    input  oper_t       st_op,
    input  logic [1:0]  addr_lo,
    input  word_t       st_data,
    output be_t         be,
    output word_t       wdata,
    output logic        misalign_raw
);

    always_comb begin
        be           = '0;
        wdata        = '0;
        misalign_raw = 1'b0;
        case (st_op)
            OP_SB: begin
                be    = be_t'(4'b0001 << addr_lo);
                wdata = {4{st_data[7:0]}};
            end
            OP_SH: begin
                misalign_raw = addr_lo[0];
                be           = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata        = {2{st_data[15:0]}};
            end
            OP_SW: begin
                misalign_raw = (addr_lo != 2'b00);
                be           = 4'b1111;
                wdata        = st_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store sequencer: accepts one aligned store, holds a req/ack bus
// transaction until ack, error or timeout, and stalls the pipe meanwhile.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  st_valid,
    input  oper_t st_op,
    input  word_t st_addr,
    input  word_t st_data,
    input  logic  flush,
    output logic  stall,
    output logic  st_done,
    output logic  misalign,
    output logic  bus_fault,
    output logic  bus_req,
    output logic  bus_we,
    output word_t bus_addr,
    output word_t bus_wdata,
    output be_t   bus_be,
    input  logic  bus_ack,
    input  logic  bus_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    st_state_t        state, state_nxt;
    bus_beat_t        beat;
    logic [CNT_W-1:0] tmo_cnt;

    be_t   al_be;
    word_t al_wdata;
    logic  al_mis;

    logic is_store, accept, cnt_max, ack_ok, fault_hit, term;

    store_align u_align (
        .st_op        (st_op),
        .addr_lo      (st_addr[1:0]),
        .st_data      (st_data),
        .be           (al_be),
        .wdata        (al_wdata),
        .misalign_raw (al_mis)
    );

    assign is_store  = st_valid & is_store_op(st_op);
    assign accept    = is_store & ~al_mis & ~flush;
    assign cnt_max   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // Error outranks ack; ack outranks a timeout landing on the same cycle.
    assign ack_ok    = bus_ack & ~bus_err;
    assign fault_hit = bus_err | (~bus_ack & cnt_max);
    assign term      = bus_ack | bus_err | cnt_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (term)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        st_done   = 1'b0;
        misalign  = 1'b0;
        bus_fault = 1'b0;
        bus_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                stall    = accept;
                misalign = is_store & al_mis & ~flush;
            end
            ST_BUSY: begin
                bus_req   = 1'b1;
                st_done   = ack_ok;
                bus_fault = fault_hit;
                stall     = ~term;
            end
            default: ;
        endcase
    end

    assign bus_we    = bus_req;
    assign bus_addr  = beat.addr;
    assign bus_wdata = beat.wdata;
    assign bus_be    = beat.be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (state == ST_IDLE && accept) begin
            beat.addr  <= {st_addr[31:2], 2'b00};
            beat.wdata <= al_wdata;
            beat.be    <= al_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           tmo_cnt <= '0;
        else if (state == ST_BUSY && !term) tmo_cnt <= tmo_cnt + 1'b1;
        else                               tmo_cnt <= '0;
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: lane steering sweep, directed vector
// table, hand-written reset/flush sequences and randomized stores.
module tb_store_unit;
    import store_unit_pkg::*;

    localparam int TO = 16;

    logic  clk = 1'b0;
    logic  rst;
    logic  st_valid, flush, bus_ack, bus_err;
    oper_t st_op;
    word_t st_addr, st_data;
    logic  stall, st_done, misalign, bus_fault, bus_req, bus_we;
    word_t bus_addr, bus_wdata;
    be_t   bus_be;

    oper_t      al_op;
    logic [1:0] al_a;
    word_t      al_data, al_wdata;
    be_t        al_be;
    logic       al_mis;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .flush(flush),
        .stall(stall), .st_done(st_done), .misalign(misalign),
        .bus_fault(bus_fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    store_align u_al (
        .st_op(al_op), .addr_lo(al_a), .st_data(al_data),
        .be(al_be), .wdata(al_wdata), .misalign_raw(al_mis)
    );

    typedef struct {
        oper_t op;
        word_t addr;
        word_t data;
        int    ack_at;   // BUSY cycle that sees ack (0 = never)
        bit    err;      // bus_err alongside ack at ack_at
        bit    fl;       // flush held high while BUSY
        be_t   be;
        word_t wd;
        bit    mis;
    } vec_t;

    vec_t  tbl[13];
    oper_t sops[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a store of size sz touches lanes a..a+sz-1, lane i carries byte i%sz.
    function automatic void model(input oper_t op, input logic [1:0] a, input word_t d,
                                  output be_t be, output word_t wd, output bit mis);
        int sz;
        sz  = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : 4;
        mis = (int'(a) % sz) != 0;
        for (int i = 0; i < 4; i++) begin
            be[i]       = (i >= int'(a)) && (i < int'(a) + sz);
            wd[8*i +: 8] = d[8*(i % sz) +: 8];
        end
    endfunction

    task automatic run_store(input oper_t op, input word_t addr, input word_t data,
                             input int ack_at, input bit err, input bit fl,
                             input be_t ebe, input word_t ewd, input bit emis);
        bit a_now, done_e, fault_e;
        st_valid = 1'b1; st_op = op; st_addr = addr; st_data = data;
        flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        chk("acc_req",   bus_req,  1'b0);
        chk("acc_stall", stall,    !emis);
        chk("acc_mis",   misalign, emis);
        chk("acc_done",  st_done,  1'b0);
        chk("acc_fault", bus_fault, 1'b0);
        @(posedge clk); #1;
        st_valid = 1'b0; st_op = OP_NOP;
        if (emis) begin
            @(negedge clk);
            chk("mis_noreq", bus_req, 1'b0);
            chk("mis_stall", stall,   1'b0);
            @(posedge clk); #1;
            return;
        end
        for (int cyc = 1; cyc <= TO; cyc++) begin
            a_now   = (cyc == ack_at);
            bus_ack = a_now;
            bus_err = err && a_now;
            flush   = fl;
            done_e  = a_now && !err;
            fault_e = (a_now && err) || (!a_now && cyc == TO);
            @(negedge clk);
            chk("busy_req",   bus_req,   1'b1);
            chk("busy_we",    bus_we,    1'b1);
            chk("busy_addr",  bus_addr,  {addr[31:2], 2'b00});
            chk("busy_be",    bus_be,    ebe);
            chk("busy_wdata", bus_wdata, ewd);
            chk("busy_done",  st_done,   done_e);
            chk("busy_fault", bus_fault, fault_e);
            chk("busy_stall", stall,     !(done_e || fault_e));
            chk("busy_mis",   misalign,  1'b0);
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
            if (done_e || fault_e) break;
        end
    endtask

    task automatic idle_cycle(input bit v, input oper_t op, input bit fl, input bit ack);
        st_valid = v; st_op = op; st_addr = 32'h0000_A000; st_data = 32'h1;
        flush = fl; bus_ack = ack; bus_err = ack;
        @(negedge clk);
        chk("idle_stall", stall,     1'b0);
        chk("idle_mis",   misalign,  1'b0);
        chk("idle_done",  st_done,   1'b0);
        chk("idle_fault", bus_fault, 1'b0);
        @(posedge clk); #1;
        st_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        chk("idle_noreq", bus_req, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        be_t   mbe;
        word_t mwd;
        bit    mmis;
        oper_t rop;
        word_t raddr, rdata;
        int    r, rack;
        bit    rerr;

        sops[0] = OP_SB; sops[1] = OP_SH; sops[2] = OP_SW;
        tbl[0]  = '{OP_SB, 32'h0000_1003, 32'h0000_00AB, 3,  1'b0, 1'b0, 4'b1000, 32'hABAB_ABAB, 1'b0};
        tbl[1]  = '{OP_SH, 32'h0000_2002, 32'h0000_1234, 1,  1'b0, 1'b0, 4'b1100, 32'h1234_1234, 1'b0};
        tbl[2]  = '{OP_SW, 32'h0000_3000, 32'hDEAD_BEEF, 2,  1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{OP_SH, 32'h0000_2001, 32'h0000_1234, 1,  1'b0, 1'b0, 4'b0000, 32'h0,         1'b1};
        tbl[4]  = '{OP_SW, 32'h0000_3002, 32'hDEAD_BEEF, 1,  1'b0, 1'b0, 4'b0000, 32'h0,         1'b1};
        tbl[5]  = '{OP_SW, 32'h0000_4000, 32'hCAFE_F00D, 1,  1'b1, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b0};
        tbl[6]  = '{OP_SW, 32'h0000_5004, 32'h1122_3344, 0,  1'b0, 1'b0, 4'b1111, 32'h1122_3344, 1'b0};
        tbl[7]  = '{OP_SH, 32'h0000_6000, 32'hBEEF_5678, 2,  1'b0, 1'b1, 4'b0011, 32'h5678_5678, 1'b0};
        tbl[8]  = '{OP_SB, 32'h0000_7001, 32'h0000_0055, 1,  1'b0, 1'b0, 4'b0010, 32'h5555_5555, 1'b0};
        tbl[9]  = '{OP_SB, 32'h0000_7002, 32'h0000_0066, 1,  1'b0, 1'b0, 4'b0100, 32'h6666_6666, 1'b0};
        tbl[10] = '{OP_SH, 32'h0000_7003, 32'h0000_7777, 1,  1'b0, 1'b0, 4'b0000, 32'h0,         1'b1};
        tbl[11] = '{OP_SW, 32'h0000_7008, 32'h0BAD_0BAD, 2,  1'b1, 1'b0, 4'b1111, 32'h0BAD_0BAD, 1'b0};
        tbl[12] = '{OP_SB, 32'h0000_8000, 32'h0000_00C3, TO, 1'b0, 1'b0, 4'b0001, 32'hC3C3_C3C3, 1'b0};

        rst = 1'b1; st_valid = 1'b0; st_op = OP_NOP; st_addr = '0; st_data = '0;
        flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
        al_op = OP_NOP; al_a = 2'b00; al_data = '0;

        // Lane steering sweep over every store op and address offset.
        for (int o = 0; o < 3; o++)
            for (int a = 0; a < 4; a++)
                for (int k = 0; k < 3; k++) begin
                    al_op = sops[o]; al_a = 2'(a); al_data = $urandom;
                    #1;
                    model(al_op, al_a, al_data, mbe, mwd, mmis);
                    chk("align_mis", al_mis, mmis);
                    if (!mmis) begin
                        chk("align_be",    al_be,    mbe);
                        chk("align_wdata", al_wdata, mwd);
                    end
                end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   bus_req,   1'b0);
        chk("rst_we",    bus_we,    1'b0);
        chk("rst_stall", stall,     1'b0);
        chk("rst_addr",  bus_addr,  32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_be",    bus_be,    4'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_store(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].ack_at, tbl[i].err,
                      tbl[i].fl, tbl[i].be, tbl[i].wd, tbl[i].mis);

        idle_cycle(1'b1, OP_SW,  1'b1, 1'b0);  // flush with a store in IDLE
        idle_cycle(1'b1, OP_ADD, 1'b0, 1'b0);  // non-store op
        idle_cycle(1'b0, OP_NOP, 1'b0, 1'b1);  // stray ack/err outside BUSY

        // Reset mid-BUSY: req must drop before the next clock edge.
        st_valid = 1'b1; st_op = OP_SW; st_addr = 32'h0000_9000; st_data = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        st_valid = 1'b0; st_op = OP_NOP;
        @(negedge clk);
        chk("pre_rst_req", bus_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req",   bus_req,   1'b0);
        chk("arst_we",    bus_we,    1'b0);
        chk("arst_done",  st_done,   1'b0);
        chk("arst_fault", bus_fault, 1'b0);
        chk("arst_stall", stall,     1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_store(OP_SB, 32'h0000_9001, 32'h0000_005A, 1, 1'b0, 1'b0, 4'b0010, 32'h5A5A_5A5A, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rop   = sops[$urandom_range(0, 2)];
            raddr = $urandom;
            rdata = $urandom;
            r     = $urandom_range(0, 9);
            rerr  = (r == 1);
            rack  = (r == 0) ? 0 : $urandom_range(1, 4);
            model(rop, raddr[1:0], rdata, mbe, mwd, mmis);
            run_store(rop, raddr, rdata, rack, rerr, ($urandom_range(0, 3) == 0),
                      mbe, mwd, mmis);
            if ($urandom_range(0, 2) == 0) idle_cycle(1'b0, OP_NOP, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
